pal_cfg_loader: RTL and testbench
=================================

PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter N, default 8, the number of PAL inputs.
REQ-002 SHALL have parameter M, default 8, the number of PAL outputs.
REQ-003 SHALL have parameter P, default 16, the number of intermediate (product) stages.
REQ-004 SHALL have parameter W, default 8, the host word width in bits.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RES, input, 1 bit: the reset; it is synchronous and active-high.
REQ-007 SHALL have port START, input, 1 bit: begins a configuration load.
REQ-008 SHALL have port ABORT, input, 1 bit: cancels a load in progress.
REQ-009 SHALL have port DIN, input, W bits: the configuration word from the host.
REQ-010 SHALL have port DIN_VALID, input, 1 bit: DIN holds a valid word.
REQ-011 SHALL have port DIN_READY, output, 1 bit: the loader accepts DIN this cycle.
REQ-012 SHALL have port CFG_BIT, output, 1 bit: the serial configuration bit to the PAL CFG input.
REQ-013 SHALL have port CFG_SHIFT, output, 1 bit: CFG_BIT is valid and the PAL shift chain advances.
REQ-014 SHALL have port CFG_APPLY, output, 1 bit: drives the PAL EN input to apply the loaded configuration.
REQ-015 SHALL have ports BUSY, DONE and ERR, outputs, 1 bit each: the load status.

Function
REQ-016 The configuration length SHALL be L = P*(2N+M) bits, which is 384 bits at the defaults; words needed SHALL be ceil(L/W).
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, APPLY and DONE.
REQ-018 In IDLE or DONE, START=1 SHALL go to LOAD next cycle, clear DONE and ERR, and zero the bit counter.
REQ-019 START SHALL be ignored in LOAD, SHIFT and APPLY.
REQ-020 In LOAD, DIN_READY SHALL be 1; DIN_READY SHALL be 0 in every other state.
REQ-021 In LOAD, DIN_VALID=1 SHALL capture DIN into the shift register and go to SHIFT next cycle.
REQ-022 In SHIFT, the loader SHALL shift one bit per cycle, LSB first, with CFG_SHIFT=1, CFG_BIT = shift register bit 0, and the bit counter incremented each cycle.
REQ-023 Leaving SHIFT: after W bits with counter < L, SHALL go to LOAD; when counter = L, SHALL go to APPLY.
REQ-024 A final partial word SHALL shift only L mod W bits; its upper bits SHALL be discarded.
REQ-025 In APPLY, CFG_APPLY SHALL be 1 for exactly one cycle, then the FSM SHALL go to DONE.
REQ-026 DONE SHALL stay 1 until the next accepted START.
REQ-027 BUSY SHALL be 1 in LOAD, SHIFT and APPLY.
REQ-028 CFG_SHIFT and CFG_APPLY SHALL never both be 1 in the same cycle.
REQ-029 CFG_BIT SHALL be 0 whenever CFG_SHIFT=0.
REQ-030 Throughput without stalls SHALL be W+1 cycles per word; host stalls in LOAD SHALL be unbounded and SHALL keep the counter value.
REQ-031 ABORT=1 in LOAD or SHIFT SHALL go to IDLE next cycle with no CFG_APPLY pulse and DONE=0.
REQ-032 ABORT SHALL be ignored in APPLY, DONE and IDLE.
REQ-033 ABORT SHALL take priority over DIN_VALID in the same cycle.

Reset
REQ-034 RES=1 at a clock edge SHALL force IDLE, zero the counter and shift register, and drive every output to 0, including mid-load.
REQ-035 No CFG_APPLY pulse SHALL follow a reset before a new START.

Configuration
REQ-036 With PAL_CFG_CRC_EN defined, after L bits the FSM SHALL accept one extra word in LOAD holding the CRC-8 (polynomial 0x07, init 0x00) of the L shifted bits in shift order.
REQ-037 With PAL_CFG_CRC_EN defined, a CRC match SHALL go to APPLY; a mismatch SHALL go to DONE with ERR=1 and no CFG_APPLY pulse.
REQ-038 Without PAL_CFG_CRC_EN, no CRC word SHALL be accepted and ERR SHALL be constant 0.

Structure
REQ-039 A shared package pal_pkg SHALL hold the FSM state enum, the default N/M/P values and the L-computation function.
REQ-040 The CRC-8 update SHALL be the sub-module pal_crc8, instantiated only under PAL_CFG_CRC_EN.

Verification
REQ-041 Defaults, 48 words 0xA5 streamed back-to-back: 384 CFG_SHIFT cycles, CFG_BIT pattern 1,0,1,0,0,1,0,1 repeating, CFG_APPLY exactly once 1 cycle after the last bit, DONE=1.
REQ-042 N=2, M=1, P=3 (L=15), W=8, words 0xFF then 0x7F: 15 shift cycles, with the 16th bit of the second word dropped.
REQ-043 ABORT asserted at bit 100: IDLE next cycle, no CFG_APPLY, DONE=0; a new START then completes a full load.
REQ-044 RES asserted during SHIFT: all outputs 0 next cycle; START during LOAD is ignored (counter unchanged).
REQ-045 PAL_CFG_CRC_EN defined: correct CRC gives CFG_APPLY=1; CRC XOR 0x01 gives ERR=1, DONE=1 and no CFG_APPLY.
REQ-046 DIN_VALID held low for 20 cycles mid-load: DIN_READY stays 1, CFG_SHIFT stays 0, and the final CFG_BIT stream is identical to the unstalled run.

Source files
------------

// File: rtl/pal_pkg.sv
// pal_pkg: shared FSM state type, default PAL geometry and configuration-length helper.
//   N_DEF/M_DEF/P_DEF : default PAL inputs, outputs and product stages
//   state_t           : loader FSM states
//   pal_len()         : configuration length in bits, P*(2N+M)
package pal_pkg;
    localparam int N_DEF = 8;
    localparam int M_DEF = 8;
    localparam int P_DEF = 16;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_APPLY, S_DONE} state_t;
    function automatic int pal_len(input int n, input int m, input int p);
        return p * (2 * n + m);
    endfunction
endpackage

// File: rtl/pal_crc8.sv
// pal_crc8: bit-serial CRC-8 (poly 0x07, init 0x00) accumulated over the shifted configuration bits.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the CRC at 0x00
//   en       : fold din into the CRC this cycle
//   din      : serial input bit
//   crc      : current CRC value
module pal_crc8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    logic fb;
    assign fb = crc[7] ^ din;
    always_ff @(posedge clk) begin
        if (rst || clr) crc <= 8'h00;
        else if (en) crc <= {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams host configuration words LSB-first into a PAL shift chain, then pulses apply.
//   CLK, RES          : clock, synchronous active-high reset
//   START, ABORT      : begin a load / cancel a load in LOAD or SHIFT
//   DIN, DIN_VALID    : host word and its valid; DIN_READY high while waiting for a word
//   CFG_BIT/CFG_SHIFT : serial configuration bit and its shift strobe
//   CFG_APPLY         : one-cycle enable pulse once the whole configuration is loaded
//   BUSY, DONE, ERR   : load status
// Optional feature macro PAL_CFG_CRC_EN: an extra CRC-8 word follows the data; a mismatch ends in DONE with ERR.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int P = P_DEF,
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         START,
    input  logic         ABORT,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VALID,
    output logic         DIN_READY,
    output logic         CFG_BIT,
    output logic         CFG_SHIFT,
    output logic         CFG_APPLY,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);
    localparam int L  = pal_len(N, M, P);
    localparam int CW = $clog2(L + 1);
    localparam int BW = $clog2(W + 1);

    state_t         state, nxt;
    logic [W-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  nb;
    logic           start_ok, take, last_bit, word_end, crc_ph, crc_ok;

    assign start_ok = (state == S_IDLE || state == S_DONE) && START;
    assign take     = state == S_LOAD && DIN_VALID && !ABORT;
    assign last_bit = cnt == CW'(L - 1);
    assign word_end = nb == BW'(W - 1);
    // the counter only reaches L while in LOAD when waiting for the CRC word
    assign crc_ph   = cnt == CW'(L);

`ifdef PAL_CFG_CRC_EN
    localparam bit CRC_EN = 1'b1;
    logic [7:0] crc;
    logic       err_q;
    pal_crc8 u_crc (
        .clk (CLK),
        .rst (RES),
        .clr (start_ok),
        .en  (CFG_SHIFT),
        .din (sr[0]),
        .crc (crc)
    );
    assign crc_ok = crc == 8'(DIN);
    always_ff @(posedge CLK) begin
        if (RES || start_ok) err_q <= 1'b0;
        else if (take && crc_ph && !crc_ok) err_q <= 1'b1;
    end
    assign ERR = err_q;
`else
    localparam bit CRC_EN = 1'b0;
    assign crc_ok = 1'b1;
    assign ERR    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
            nb    <= '0;
        end else begin
            state <= nxt;
            if (start_ok) cnt <= '0;
            if (take) begin
                sr <= DIN;
                nb <= '0;
            end
            if (CFG_SHIFT) begin
                sr  <= sr >> 1;
                cnt <= cnt + 1'b1;
                nb  <= nb + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_DONE: nxt = START ? S_LOAD : state;
            S_LOAD: begin
                if (ABORT) nxt = S_IDLE;
                else if (DIN_VALID) nxt = crc_ph ? (crc_ok ? S_APPLY : S_DONE) : S_SHIFT;
            end
            S_SHIFT: begin
                if (ABORT) nxt = S_IDLE;
                else if (last_bit) nxt = CRC_EN ? S_LOAD : S_APPLY;
                else if (word_end) nxt = S_LOAD;
            end
            S_APPLY: nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    assign DIN_READY = state == S_LOAD;
    assign CFG_SHIFT = state == S_SHIFT;
    assign CFG_BIT   = CFG_SHIFT & sr[0];
    assign CFG_APPLY = state == S_APPLY;
    assign BUSY      = state == S_LOAD || state == S_SHIFT || state == S_APPLY;
    assign DONE      = state == S_DONE;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: randomized load scenarios checked against a word-to-bitstream reference model.
module tb_pal_cfg_loader;
    localparam int L = 16 * (2 * 8 + 8);
`ifdef PAL_CFG_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RES, START, ABORT, DIN_VALID;
    logic [7:0] DIN;
    logic       DIN_READY, CFG_BIT, CFG_SHIFT, CFG_APPLY, BUSY, DONE, ERR;
    logic       s_start, s_valid;
    logic [7:0] s_din;
    logic       s_ready, s_bit, s_shift, s_apply, s_busy, s_done, s_err;

    pal_cfg_loader u_dut (
        .CLK(clk), .RES(RES), .START(START), .ABORT(ABORT), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .CFG_BIT(CFG_BIT), .CFG_SHIFT(CFG_SHIFT), .CFG_APPLY(CFG_APPLY),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    pal_cfg_loader #(.N(2), .M(1), .P(3), .W(8)) u_small (
        .CLK(clk), .RES(RES), .START(s_start), .ABORT(1'b0), .DIN(s_din), .DIN_VALID(s_valid),
        .DIN_READY(s_ready), .CFG_BIT(s_bit), .CFG_SHIFT(s_shift), .CFG_APPLY(s_apply),
        .BUSY(s_busy), .DONE(s_done), .ERR(s_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit mon_clr = 1'b1;
    bit q[$];
    int n_apply, n_overlap, n_bit_noshift, first_shift, last_shift, apply_cyc;
    int s_n, s_ones, s_napply;

    always @(negedge clk) begin
        if (mon_clr) begin
            q.delete();
            n_apply = 0; n_overlap = 0; n_bit_noshift = 0;
            first_shift = 0; last_shift = 0; apply_cyc = 0;
            s_n = 0; s_ones = 0; s_napply = 0;
        end else begin
            if (CFG_SHIFT) begin
                if (q.size() == 0) first_shift = cyc;
                q.push_back(CFG_BIT);
                last_shift = cyc;
            end
            if (CFG_APPLY) begin
                n_apply++;
                apply_cyc = cyc;
            end
            if (CFG_SHIFT && CFG_APPLY) n_overlap++;
            if (!CFG_SHIFT && CFG_BIT) n_bit_noshift++;
            if (s_shift) begin
                s_n++;
                s_ones += int'(s_bit);
            end
            if (s_apply) s_napply++;
        end
    end

    logic [7:0] words[$];

    function automatic void build_bits(input logic [7:0] w[$], input int len, output bit b[$]);
        b.delete();
        foreach (w[i]) for (int j = 0; j < 8; j++) if (b.size() < len) b.push_back(w[i][j]);
    endfunction

    function automatic logic [7:0] crc8(input bit b[$]);
        logic [7:0] c = 8'h00;
        foreach (b[i]) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic rand_words();
        words.delete();
        repeat ((L + 7) / 8) words.push_back(8'($urandom));
    endtask

    task automatic run_load(input int stall_word, input int abort_bit, input int rst_bit,
                            input int start_word, input bit crc_bad);
        bit exp[$];
        int nw, t, bad, mism;
        logic [7:0] cw;
        build_bits(words, L, exp);
        cw = crc8(exp) ^ {7'd0, crc_bad};
        nw = words.size();
        mon_reset();
        @(posedge clk); #1;
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        for (int k = 0; k < nw + CRC_WORDS; k++) begin
            t = 0;
            while (!DIN_READY && t < 100) begin
                if (abort_bit >= 0 && q.size() >= abort_bit) begin
                    ABORT = 1'b1;
                    @(posedge clk); #1;
                    ABORT = 1'b0;
                    check("abort_busy", BUSY, 0);
                    check("abort_done", DONE, 0);
                    repeat (4) @(posedge clk);
                    #1;
                    check("abort_bits", q.size(), abort_bit + 1);
                    check("abort_apply", n_apply, 0);
                    check("abort_ready", DIN_READY, 0);
                    return;
                end
                if (rst_bit >= 0 && q.size() >= rst_bit) begin
                    RES = 1'b1;
                    @(posedge clk); #1;
                    check("rst_outputs", {DIN_READY, CFG_BIT, CFG_SHIFT, CFG_APPLY, BUSY, DONE, ERR}, 0);
                    RES = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    check("rst_no_apply", n_apply, 0);
                    check("rst_done", DONE, 0);
                    return;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!DIN_READY) begin
                check("ready_timeout", DIN_READY, 1);
                return;
            end
            if (k == stall_word) begin
                bad = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (!DIN_READY || CFG_SHIFT) bad++;
                end
                check("stall_hold", bad, 0);
            end
            if (k == start_word) begin
                START = 1'b1;
                @(posedge clk); #1;
                START = 1'b0;
                check("start_in_load", {DIN_READY, BUSY}, 2'b11);
            end
            DIN = k < nw ? words[k] : cw;
            DIN_VALID = 1'b1;
            @(posedge clk); #1;
            DIN_VALID = 1'b0;
        end
        t = 0;
        while (BUSY && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("busy_end", BUSY, 0);
        mism = 0;
        foreach (exp[i]) if (i >= q.size() || q[i] != exp[i]) mism++;
        check("shift_count", q.size(), L);
        check("stream_mismatches", mism, 0);
        check("shift_apply_overlap", n_overlap, 0);
        check("bit_without_shift", n_bit_noshift, 0);
        check("done", DONE, 1);
        if (crc_bad) begin
            check("crc_err", ERR, 1);
            check("crc_no_apply", n_apply, 0);
        end else begin
            check("err", ERR, 0);
            check("apply_count", n_apply, 1);
            check("apply_gap", apply_cyc - last_shift, 1 + CRC_WORDS);
        end
        if (stall_word < 0 && start_word < 0)
            check("span", last_shift - first_shift + 1, L + nw - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit sexp[$];
        int t;
        RES = 1'b1; START = 1'b0; ABORT = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {DIN_READY, CFG_BIT, CFG_SHIFT, CFG_APPLY, BUSY, DONE, ERR}, 0);
        check("reset_small", {s_ready, s_bit, s_shift, s_apply, s_busy, s_done, s_err}, 0);
        RES = 1'b0;

        words.delete();
        repeat (48) words.push_back(8'hA5);
        run_load(-1, -1, -1, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_words();
            run_load(-1, -1, -1, -1, 1'b0);
        end

        rand_words();
        run_load(20, -1, -1, 5, 1'b0);

        rand_words();
        run_load(-1, 100, -1, -1, 1'b0);
        rand_words();
        run_load(-1, -1, -1, -1, 1'b0);

        rand_words();
        run_load(-1, -1, 50, -1, 1'b0);
        rand_words();
        run_load(-1, -1, -1, -1, 1'b0);

`ifdef PAL_CFG_CRC_EN
        rand_words();
        run_load(-1, -1, -1, -1, 1'b1);
        rand_words();
        run_load(-1, -1, -1, -1, 1'b0);
`endif

        words.delete();
        words.push_back(8'hFF);
        words.push_back(8'h7F);
        build_bits(words, 15, sexp);
        mon_reset();
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int k = 0; k < 2 + CRC_WORDS; k++) begin
            t = 0;
            while (!s_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            s_din = k < 2 ? words[k] : crc8(sexp);
            s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0;
        end
        t = 0;
        while (s_busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("small_shifts", s_n, sexp.size());
        check("small_ones", s_ones, 15);
        check("small_apply", s_napply, 1);
        check("small_done", s_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
